// File: rtl/derm_llr_scatter_pkg.sv
// derm_pkg: shared constants, FSM state type and LLR saturating-add helpers
// for the HARQ circular-buffer scatter block.
package derm_pkg;

  localparam int LLR_W   = 6;
  localparam int LLR_MAX = 31;
  localparam int LLR_MIN = -32;
  localparam int POP_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sign-extended sum of two LLRs; one extra bit so overflow is visible.
  function automatic logic [LLR_W:0] llr_add(input logic [LLR_W-1:0] a,
                                             input logic [LLR_W-1:0] b);
    return {a[LLR_W-1], a} + {b[LLR_W-1], b};
  endfunction

  // Overflow of the 7-bit sum shows up as its top two bits disagreeing.
  function automatic logic llr_ovf(input logic [LLR_W:0] s);
    return s[LLR_W] != s[LLR_W-1];
  endfunction

  function automatic logic [LLR_W-1:0] llr_sat(input logic [LLR_W:0] s);
    if (llr_ovf(s)) return s[LLR_W] ? LLR_W'(LLR_MIN) : LLR_W'(LLR_MAX);
    return s[LLR_W-1:0];
  endfunction

endpackage

// File: rtl/derm_llr_scatter_if.sv
// derm_llr_scatter_if: FIFO pop handshake plus HARQ buffer read/write bus.
// Signal names carry the direction as seen from the scatter block.
interface derm_llr_scatter_if #(
  parameter int NCB_W = 16,
  parameter int LLR_W = 6
);
  logic                 o_pop_permit;
  logic [3:0]           o_pop_amount;
  logic                 i_pop_enable;
  logic [16*LLR_W-1:0]  i_pop_data;
  logic                 o_rd_en;
  logic [NCB_W-1:0]     o_rd_addr;
  logic [LLR_W-1:0]     i_rd_data;
  logic                 o_wr_en;
  logic [NCB_W-1:0]     o_wr_addr;
  logic [LLR_W-1:0]     o_wr_data;

  modport master (
    output o_pop_permit, o_pop_amount, o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, o_wr_data,
    input  i_pop_enable, i_pop_data, i_rd_data
  );

  modport slave (
    input  o_pop_permit, o_pop_amount, o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, o_wr_data,
    output i_pop_enable, i_pop_data, i_rd_data
  );
endinterface

// File: rtl/derm_llr_scatter_addr_gen.sv
// derm_addr_gen: circular-buffer position register. Steps by one, wraps at
// Ncb and jumps over the filler region in a single step.
module derm_addr_gen #(
  parameter int NCB_W = 16
) (
  input  logic             i_core_clk,
  input  logic             i_rx_rst,
  input  logic             i_load,
  input  logic             i_adv,
  input  logic [NCB_W-1:0] i_k0,
  input  logic [NCB_W-1:0] i_ncb,
  input  logic [NCB_W-1:0] i_fill_start,
  input  logic [NCB_W-1:0] i_fill_len,
  output logic [NCB_W-1:0] o_pos
);
  logic [NCB_W-1:0] r_pos;
  logic [NCB_W-1:0] w_inc;
  logic [NCB_W-1:0] w_nxt;

  // Next position: wrap first, then skip filler if we landed on its start.
  always_comb begin
    w_inc = r_pos + 1'b1;
    if (w_inc == i_ncb) w_inc = '0;
    w_nxt = w_inc;
    if ((i_fill_len != '0) && (w_inc == i_fill_start)) w_nxt = i_fill_start + i_fill_len;
  end

  // Position register: load k0 at job start, advance once per emitted LLR.
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst)    r_pos <= '0;
    else if (i_load) r_pos <= i_k0;
    else if (i_adv)  r_pos <= w_nxt;
  end

  assign o_pos = r_pos;
endmodule

// File: rtl/derm_llr_scatter.sv
// derm_llr_scatter: pops LLR chunks from the rate-matching FIFO, serialises
// them oldest-first and scatters them into the HARQ circular buffer, combining
// repeats with a saturating read-modify-write.
// Optional: define DERM_SAT_CNT_EN to add o_sat_cnt (clamped-combine count).
//
// state | meaning
// IDLE  | waiting for i_start; config latched on start
// RUN   | popping chunks, emitting one LLR per cycle (S0), writing (S1)
// DONE  | one-cycle o_done pulse after the E-th write
module derm_llr_scatter
  import derm_pkg::*;
#(
  parameter int NCB_W = 16,
  parameter int E_W   = 17
) (
  input  logic               i_core_clk,
  input  logic               i_rx_rst,
  input  logic               i_start,
  input  logic [E_W-1:0]     i_e_len,
  input  logic [NCB_W-1:0]   i_ncb,
  input  logic [NCB_W-1:0]   i_k0,
  input  logic [NCB_W-1:0]   i_fill_start,
  input  logic [NCB_W-1:0]   i_fill_len,
  derm_llr_scatter_if.master bus,
  output logic               o_busy,
  output logic               o_done
`ifdef DERM_SAT_CNT_EN
  ,
  output logic [E_W-1:0]     o_sat_cnt
`endif
);
  state_t                   r_state, w_state_nxt;
  logic [NCB_W-1:0]         r_ncb, r_fill_start, r_fill_len, w_pos;
  logic [E_W-1:0]           r_e_len, r_pop_left, r_wr_cnt, w_ring_len;
  logic [POP_MAX*LLR_W-1:0] r_ser_data;
  logic [4:0]               r_ser_cnt, w_cnt_m1, w_pop_num;
  logic                     w_start, w_run, w_emit, w_pop_req, w_pop, w_comb, w_last;
  logic [LLR_W-1:0]         w_llr;
  logic                     r_s1_vld, r_s1_comb, r_s1_last;
  logic [NCB_W-1:0]         r_s1_addr;
  logic [LLR_W-1:0]         r_s1_llr;
  logic [LLR_W:0]           w_sum;

  assign w_start    = i_start && (r_state == IDLE);
  assign w_run      = (r_state == RUN);
  assign w_emit     = w_run && (r_ser_cnt != 5'd0);
  assign w_pop_req  = w_run && (r_pop_left != '0) && (r_ser_cnt <= 5'd1);
  assign w_pop      = w_pop_req && bus.i_pop_enable;
  assign w_pop_num  = (r_pop_left >= E_W'(POP_MAX)) ? 5'(POP_MAX) : r_pop_left[4:0];
  assign w_cnt_m1   = r_ser_cnt - 5'd1;
  // Oldest held LLR sits at the highest occupied symbol.
  assign w_llr      = r_ser_data[w_cnt_m1[3:0]*LLR_W +: LLR_W];
  assign w_ring_len = E_W'(r_ncb - r_fill_len);
  assign w_comb     = (r_wr_cnt >= w_ring_len);
  assign w_last     = (r_wr_cnt == r_e_len - 1'b1);
  assign w_sum      = llr_add(r_s1_llr, bus.i_rd_data);

  derm_addr_gen #(.NCB_W(NCB_W)) u_addr_gen (
    .i_core_clk   (i_core_clk),
    .i_rx_rst     (i_rx_rst),
    .i_load       (w_start),
    .i_adv        (w_emit),
    .i_k0         (i_k0),
    .i_ncb        (r_ncb),
    .i_fill_start (r_fill_start),
    .i_fill_len   (r_fill_len),
    .o_pos        (w_pos)
  );

  // FSM state register.
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state: the job ends when the last LLR leaves the write stage.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = RUN;
      RUN:     if (r_s1_vld && r_s1_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Config latch, pop bookkeeping and serialiser; a chunk may load in the
  // same cycle the last held LLR is emitted.
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      r_ncb        <= '0;
      r_fill_start <= '0;
      r_fill_len   <= '0;
      r_e_len      <= '0;
      r_pop_left   <= '0;
      r_wr_cnt     <= '0;
      r_ser_data   <= '0;
      r_ser_cnt    <= '0;
    end else if (w_start) begin
      r_ncb        <= i_ncb;
      r_fill_start <= i_fill_start;
      r_fill_len   <= i_fill_len;
      r_e_len      <= i_e_len;
      r_pop_left   <= i_e_len;
      r_wr_cnt     <= '0;
      r_ser_cnt    <= '0;
    end else begin
      if (w_pop) begin
        r_ser_data <= bus.i_pop_data;
        r_ser_cnt  <= w_pop_num;
        r_pop_left <= r_pop_left - E_W'(w_pop_num);
      end else if (w_emit) begin
        r_ser_cnt  <= r_ser_cnt - 5'd1;
      end
      if (w_emit) r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end

  // Write stage S1: a fixed one-cycle delay of S0, lined up with read data.
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_comb <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_addr <= '0;
      r_s1_llr  <= '0;
    end else begin
      r_s1_vld  <= w_emit;
      r_s1_comb <= w_emit && w_comb;
      r_s1_last <= w_emit && w_last;
      r_s1_addr <= w_pos;
      r_s1_llr  <= w_llr;
    end
  end

`ifdef DERM_SAT_CNT_EN
  // Count combines whose sum had to be clamped; holds after the job.
  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst)                                  o_sat_cnt <= '0;
    else if (w_start)                              o_sat_cnt <= '0;
    else if (r_s1_vld && r_s1_comb && llr_ovf(w_sum)) o_sat_cnt <= o_sat_cnt + 1'b1;
  end
`endif

  assign bus.o_pop_permit = w_pop_req;
  assign bus.o_pop_amount = (r_pop_left == '0) ? 4'd0 : w_cnt_m1_pop();
  assign bus.o_rd_en      = w_emit && w_comb;
  assign bus.o_rd_addr    = w_pos;
  assign bus.o_wr_en      = r_s1_vld;
  assign bus.o_wr_addr    = r_s1_addr;
  assign bus.o_wr_data    = r_s1_comb ? llr_sat(w_sum) : r_s1_llr;
  assign o_busy           = (r_state == RUN) || (r_state == DONE);
  assign o_done           = (r_state == DONE);

  function automatic logic [3:0] w_cnt_m1_pop();
    logic [4:0] v;
    v = w_pop_num - 5'd1;
    return v[3:0];
  endfunction
endmodule

// File: tb/tb_derm_llr_scatter.sv
// Self-checking bench for derm_llr_scatter. The bench plays the LLR FIFO and
// the HARQ buffer RAM; a ring-position model predicts every buffer access.
module tb_derm_llr_scatter;
  logic        clk;
  logic        rst;
  logic        i_start;
  logic [16:0] i_e_len;
  logic [15:0] i_ncb, i_k0, i_fill_start, i_fill_len;
  logic        busy, done;
`ifdef DERM_SAT_CNT_EN
  logic [16:0] sat_cnt;
`endif

  derm_llr_scatter_if bus ();

  derm_llr_scatter dut (
    .i_core_clk   (clk),
    .i_rx_rst     (rst),
    .i_start      (i_start),
    .i_e_len      (i_e_len),
    .i_ncb        (i_ncb),
    .i_k0         (i_k0),
    .i_fill_start (i_fill_start),
    .i_fill_len   (i_fill_len),
    .bus          (bus),
    .o_busy       (busy),
    .o_done       (done)
`ifdef DERM_SAT_CNT_EN
    ,
    .o_sat_cnt    (sat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int s6(input logic [5:0] x);
    return int'($signed(x));
  endfunction

  // ---------------- HARQ buffer RAM (1-cycle read latency)
  logic [5:0] mem [0:63];
  logic [5:0] rd_q;
  logic       mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 6'd5;
    end else begin
      if (bus.o_rd_en) rd_q <= mem[bus.o_rd_addr[5:0]];
      if (bus.o_wr_en) mem[bus.o_wr_addr[5:0]] <= bus.o_wr_data;
    end
  end
  assign bus.i_rd_data = rd_q;

  // ---------------- job description shared with the model
  logic [5:0] llr_arr [0:63];
  int j_ncb, j_k0, j_fs, j_fl, j_e;
  int job_seq = 0;
  bit chk_en  = 0;
  bit stall_arm = 0;

  // ---------------- FIFO + scoreboard state
  logic [5:0] fifo_q [$];
  int exp_wa [$];
  int exp_wd [$];
  int exp_rd [$];
  int seen_seq = 0;
  int n_grants = 0;
  int pop_log [0:15];
  bit done_due = 0;
  int stall_left = 0;
  int stall_amt = 0;
  int stall_used = 0;

  // Model: list of ring positions (filler removed) walked from k0; pass one
  // writes raw LLRs, later passes add to what the earlier pass left.
  task automatic load_job();
    int ring [$];
    int refm [64];
    int len, idx0, a, d, v;
    fifo_q.delete(); exp_wa.delete(); exp_wd.delete(); exp_rd.delete();
    n_grants = 0;
    done_due = 0;
    for (int p = 0; p < j_ncb; p++)
      if (!(j_fl != 0 && p >= j_fs && p < j_fs + j_fl)) ring.push_back(p);
    len = ring.size();
    idx0 = 0;
    for (int i = 0; i < len; i++) if (ring[i] == j_k0) idx0 = i;
    for (int i = 0; i < j_e; i++) begin
      fifo_q.push_back(llr_arr[i]);
      a = ring[(idx0 + i) % len];
      v = s6(llr_arr[i]);
      if (i < len) d = v;
      else begin
        d = v + refm[a];
        if (d > 31) d = 31;
        if (d < -32) d = -32;
        exp_rd.push_back(a);
      end
      refm[a] = d;
      exp_wa.push_back(a);
      exp_wd.push_back(d & 63);
    end
  endtask

  // FIFO responder and per-cycle compare, both sampled on the falling edge.
  always @(negedge clk) begin
    int amt;
    logic [95:0] data;
    if (job_seq != seen_seq) begin
      seen_seq = job_seq;
      load_job();
    end
    bus.i_pop_enable = 1'b0;
    if (stall_left > 0) begin
      chk("stall_permit", int'(bus.o_pop_permit), 1);
      chk("stall_amount", int'(bus.o_pop_amount), stall_amt);
      if (stall_left <= 3) chk("stall_no_write", int'(bus.o_wr_en), 0);
      stall_left--;
    end else if (bus.o_pop_permit) begin
      amt = int'(bus.o_pop_amount);
      if (stall_arm && stall_used == 0 && n_grants >= 1) begin
        stall_used = 1;
        stall_amt  = amt;
        stall_left = 4;
      end else if (fifo_q.size() >= amt + 1) begin
        data = '0;
        for (int j = 0; j <= amt; j++) data[(amt-j)*6 +: 6] = fifo_q.pop_front();
        if (n_grants < 16) pop_log[n_grants] = amt;
        n_grants++;
        bus.i_pop_data   = data;
        bus.i_pop_enable = 1'b1;
      end
    end
    if (chk_en) begin
      if (done || done_due) chk("done_timing", int'(done), int'(done_due));
      done_due = 0;
      if (bus.o_rd_en) begin
        chk("rd_expected", int'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) chk("rd_addr", int'(bus.o_rd_addr), exp_rd.pop_front());
      end
      if (bus.o_wr_en) begin
        chk("wr_expected", int'(exp_wa.size() != 0), 1);
        if (exp_wa.size() != 0) begin
          chk("wr_addr", int'(bus.o_wr_addr), exp_wa.pop_front());
          chk("wr_data", int'(bus.o_wr_data), exp_wd.pop_front());
          if (exp_wa.size() == 0) done_due = 1;
        end
      end
    end else begin
      done_due = 0;
    end
  end

  // ---------------- main sequence helpers
  task automatic clear_mem();
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
  endtask

  task automatic start_job(input int ncb, input int k0, input int fs, input int fl, input int e);
    @(negedge clk);
    j_ncb = ncb; j_k0 = k0; j_fs = fs; j_fl = fl; j_e = e;
    job_seq++;
    @(negedge clk);
    i_ncb = 16'(ncb); i_k0 = 16'(k0); i_fill_start = 16'(fs); i_fill_len = 16'(fl);
    i_e_len = 17'(e);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({nm, "_done_seen"}, int'(seen), 1);
    @(negedge clk);
    chk({nm, "_writes_left"}, exp_wa.size(), 0);
    chk({nm, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic case1_checks(input string nm);
    chk({nm, "_pops"}, n_grants, 3);
    chk({nm, "_pop0"}, pop_log[0], 15);
    chk({nm, "_pop1"}, pop_log[1], 15);
    chk({nm, "_pop2"}, pop_log[2], 7);
    chk({nm, "_mem0"}, int'(mem[0]), 1);
    chk({nm, "_mem39"}, int'(mem[39]), 40);
    chk({nm, "_mem40_untouched"}, int'(mem[40]), 5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_start = 1'b0; mem_clr = 1'b0;
    i_e_len = '0; i_ncb = '0; i_k0 = '0; i_fill_start = '0; i_fill_len = '0;
    bus.i_pop_enable = 1'b0; bus.i_pop_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_permit", int'(bus.o_pop_permit), 0);
    chk("rst_amount", int'(bus.o_pop_amount), 0);
    chk("rst_wr_en", int'(bus.o_wr_en), 0);
    chk("rst_rd_en", int'(bus.o_rd_en), 0);
    rst = 1'b0;
    chk_en = 1;

    // Case 1: straight single pass, pops 16/16/8.
    for (int i = 0; i < 40; i++) llr_arr[i] = 6'(i + 1);
    clear_mem();
    start_job(64, 0, 0, 0, 40);
    wait_done("c1");
    case1_checks("c1");

    // Case 2: wrap at Ncb and combine the last two LLRs.
    for (int i = 0; i < 40; i++) llr_arr[i] = 6'((i % 16) - 4);
    clear_mem();
    start_job(32, 30, 0, 0, 34);
    wait_done("c2");
    chk("c2_mem30", s6(mem[30]), -8);
    chk("c2_mem31", s6(mem[31]), -6);
    chk("c2_mem0", s6(mem[0]), -2);

    // Case 3: filler region 10..17 skipped.
    for (int i = 0; i < 40; i++) llr_arr[i] = 6'(i * 5 + 1);
    clear_mem();
    start_job(40, 5, 10, 8, 32);
    wait_done("c3");
    for (int p = 10; p < 18; p++) chk($sformatf("c3_filler_%0d", p), int'(mem[p]), 5);
    chk("c3_mem18", int'(mem[18]), 6'(5 * 5 + 1));

    // Case 4: saturation both ways.
    for (int i = 0; i < 40; i++) llr_arr[i] = 6'd20;
    clear_mem();
    start_job(16, 0, 0, 0, 32);
    wait_done("c4p");
    chk("c4p_mem0", s6(mem[0]), 31);
    chk("c4p_mem15", s6(mem[15]), 31);
`ifdef DERM_SAT_CNT_EN
    chk("c4p_sat_cnt", int'(sat_cnt), 16);
`endif
    for (int i = 0; i < 40; i++) llr_arr[i] = 6'(-20);
    start_job(16, 0, 0, 0, 32);
    wait_done("c4n");
    chk("c4n_mem0", s6(mem[0]), -32);
    chk("c4n_mem7", s6(mem[7]), -32);
`ifdef DERM_SAT_CNT_EN
    chk("c4n_sat_cnt", int'(sat_cnt), 16);
`endif

    // Case 5: FIFO withholds its grant for five cycles mid-job.
    for (int i = 0; i < 40; i++) llr_arr[i] = 6'(i * 7 + 3);
    clear_mem();
    stall_arm = 1;
    start_job(48, 44, 20, 4, 40);
    wait_done("c5");
    stall_arm = 0;
    chk("c5_stall_seen", stall_used, 1);

    // Case 6: reset mid-RUN aborts, then case 1 replays cleanly.
    for (int i = 0; i < 40; i++) llr_arr[i] = 6'(i + 1);
    clear_mem();
    start_job(64, 0, 0, 0, 40);
    repeat (10) @(negedge clk);
    chk_en = 0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("c6_busy", int'(busy), 0);
    chk("c6_wr_en", int'(bus.o_wr_en), 0);
    chk("c6_permit", int'(bus.o_pop_permit), 0);
    repeat (3) begin
      @(negedge clk);
      chk("c6_no_done", int'(done), 0);
    end
    rst = 1'b0;
    chk_en = 1;
    clear_mem();
    start_job(64, 0, 0, 0, 40);
    wait_done("c6");
    case1_checks("c6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
